// File: rtl/audio_data_rx.sv
// rtl/audio_data_rx.sv - serial audio frame receiver with left/right word capture
// Decodes LEFT/RIGHT/GAP from a frame counter and hands words to a valid/ready consumer.
module audio_data_rx #(
  parameter int WORD_BITS = 16,
  parameter int FRAME_LEN = 251
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 data_bit,
  input  logic                 frame_sync,
  output logic [WORD_BITS-1:0] left,
  output logic [WORD_BITS-1:0] right,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overrun
);

  localparam int FCW = $clog2(FRAME_LEN);
  localparam logic [FCW-1:0] FC_LAST  = FCW'(FRAME_LEN - 1);
  localparam logic [FCW-1:0] FC_RIGHT = FCW'(WORD_BITS);
  localparam logic [FCW-1:0] FC_GAP   = FCW'(2 * WORD_BITS);
  localparam logic [FCW-1:0] FC_LOAD  = FCW'(2 * WORD_BITS - 1);

  typedef enum logic [1:0] {ST_LEFT, ST_RIGHT, ST_GAP} state_t;

  state_t                state_q, state_d, st_cur;
  logic [FCW-1:0]        fc_q, fc_d, fc_cur;
  logic [WORD_BITS-1:0]  lsr_q, lsr_d;
  logic [WORD_BITS-1:0]  rsr_q, rsr_d;
  logic [WORD_BITS-1:0]  left_q, left_d;
  logic [WORD_BITS-1:0]  right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_LEFT;
      fc_q      <= '0;
      lsr_q     <= '0;
      rsr_q     <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fc_q      <= fc_d;
      lsr_q     <= lsr_d;
      rsr_q     <= rsr_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // A qualified frame_sync makes this cycle behave as fc=0 / LEFT.
  always_comb begin
    fc_cur = (en && frame_sync) ? '0 : fc_q;
    st_cur = (en && frame_sync) ? ST_LEFT : state_q;
    fc_d   = fc_q;
    if (en) begin
      fc_d = (fc_cur == FC_LAST) ? '0 : fc_cur + FCW'(1);
    end
  end

  always_comb begin
    if (fc_d < FC_RIGHT) begin
      state_d = ST_LEFT;
    end else if (fc_d < FC_GAP) begin
      state_d = ST_RIGHT;
    end else begin
      state_d = ST_GAP;
    end
  end

  always_comb begin
    lsr_d     = lsr_q;
    rsr_d     = rsr_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    load      = en && (fc_cur == FC_LOAD);
    if (en) begin
      case (st_cur)
        ST_LEFT:  lsr_d = {lsr_q[WORD_BITS-2:0], data_bit};
        ST_RIGHT: rsr_d = {rsr_q[WORD_BITS-2:0], data_bit};
        default:  ;
      endcase
    end
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end
    // The last right bit is still on data_bit, so it is folded in here.
    if (load) begin
      left_d    = lsr_q;
      right_d   = {rsr_q[WORD_BITS-2:0], data_bit};
      valid_d   = 1'b1;
      overrun_d = valid_q && !ready;
    end
  end

  assign left    = left_q;
  assign right   = right_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_audio_data_rx.sv
// tb/tb_audio_data_rx.sv - scoreboard bench for audio_data_rx
// Stimulus pushes expected words; a monitor pops them on each valid/ready transfer.
module tb_audio_data_rx;

  localparam int W  = 16;
  localparam int FL = 251;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         en = 1'b0;
  logic         data_bit = 1'b0;
  logic         frame_sync = 1'b0;
  logic         ready = 1'b0;
  logic [W-1:0] left, right;
  logic         valid, overrun;

  int compared   = 0;
  int mismatched = 0;
  int ovr_cnt    = 0;
  int en_cnt     = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  audio_data_rx #(.WORD_BITS(W), .FRAME_LEN(FL)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .data_bit   (data_bit),
    .frame_sync (frame_sync),
    .left       (left),
    .right      (right),
    .valid      (valid),
    .ready      (ready),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic fs);
    @(negedge clk);
    en = e;
    data_bit = d;
    frame_sync = fs;
    if (e) en_cnt++;
  endtask

  task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input int spacing,
                            input logic gap_bit, input logic sync, input logic ready_on_load,
                            input logic check_pre, output int load_at);
    logic [2*W-1:0] word;
    logic d;
    word = {l, r};
    load_at = 0;
    for (int i = 0; i < FL; i++) begin
      d = (i < 2*W) ? word[2*W-1-i] : gap_bit;
      repeat (spacing - 1) step(1'b0, ~d, 1'b0);
      if (i == 2*W-1 && check_pre) check("valid_before_load", {31'd0, valid}, 32'd0);
      step(1'b1, d, sync && (i == 0));
      if (i == 2*W-1) begin
        if (ready_on_load) ready = 1'b1;
        load_at = en_cnt;
        @(posedge clk);
        #1;
        check("valid_after_load", {31'd0, valid}, 32'd1);
        check("left_after_load", {16'd0, left}, {16'd0, l});
        check("right_after_load", {16'd0, right}, {16'd0, r});
        if (ready_on_load) begin
          check("overrun_on_accept_load", {31'd0, overrun}, 32'd0);
          ready = 1'b0;
        end
      end
    end
  endtask

  // Monitor samples 1 time unit before each rising edge.
  initial begin
    logic [2*W-1:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (reset_n) begin
        if (overrun) ovr_cnt++;
        if (valid && ready) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL xfer_unexpected: got 0x%0h, expected no transfer", {left, right});
          end else begin
            exp = exp_q.pop_front();
            if ({left, right} !== exp) begin
              mismatched++;
              $display("FAIL xfer_word: got 0x%0h, expected 0x%0h", {left, right}, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int la, lb, ob;
    repeat (3) step(1'b1, 1'b1, 1'b0);
    #1;
    check("reset_left", {16'd0, left}, 32'd0);
    check("reset_right", {16'd0, right}, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // basic capture
    ready = 1'b1;
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_frame(16'hA5C3, 16'h1234, 1, 1'b0, 1'b0, 1'b0, 1'b1, la);
    check("valid_drop_after_xfer", {31'd0, valid}, 32'd0);
    check("left_hold_after_xfer", {16'd0, left}, 32'h0000A5C3);

    // frame wrap with GAP bits of 1
    exp_q.push_back({16'h8001, 16'h7FFE});
    exp_q.push_back({16'hFFFF, 16'h0000});
    send_frame(16'h8001, 16'h7FFE, 1, 1'b1, 1'b0, 1'b0, 1'b1, la);
    send_frame(16'hFFFF, 16'h0000, 1, 1'b1, 1'b0, 1'b0, 1'b1, lb);
    check("wrap_load_spacing", lb - la, 32'd251);

    // sparse enable, one cycle in four
    exp_q.push_back({16'hA5C3, 16'h1234});
    send_frame(16'hA5C3, 16'h1234, 4, 1'b1, 1'b0, 1'b0, 1'b1, la);

    // overrun: two loads without accept
    ready = 1'b0;
    ob = ovr_cnt;
    send_frame(16'h1111, 16'h2222, 1, 1'b0, 1'b0, 1'b0, 1'b1, la);
    send_frame(16'h3333, 16'h4444, 1, 1'b0, 1'b0, 1'b0, 1'b0, lb);
    check("overrun_pulses", ovr_cnt - ob, 32'd1);
    check("overrun_valid_held", {31'd0, valid}, 32'd1);
    exp_q.push_back({16'h3333, 16'h4444});
    ready = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // simultaneous accept and load
    ready = 1'b0;
    ob = ovr_cnt;
    exp_q.push_back({16'h5555, 16'h6666});
    exp_q.push_back({16'h7777, 16'h8888});
    send_frame(16'h5555, 16'h6666, 1, 1'b0, 1'b0, 1'b0, 1'b1, la);
    send_frame(16'h7777, 16'h8888, 1, 1'b0, 1'b0, 1'b1, 1'b0, lb);
    check("accept_load_no_overrun", ovr_cnt - ob, 32'd0);
    ready = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);

    // resync at fc=10 discards the partial word
    repeat (10) step(1'b1, 1'b1, 1'b0);
    exp_q.push_back({16'h00FF, 16'hFF00});
    send_frame(16'h00FF, 16'hFF00, 1, 1'b0, 1'b1, 1'b0, 1'b1, la);

    // reset at fc=20
    repeat (20) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midreset_left", {16'd0, left}, 32'd0);
    check("midreset_right", {16'd0, right}, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    exp_q.push_back({16'h1357, 16'h2468});
    send_frame(16'h1357, 16'h2468, 1, 1'b0, 1'b0, 1'b0, 1'b1, la);

    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
